// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU: stage 1 captures the operation, stage 2 computes and
// holds the result and flags, with an internal accumulator and optional saturation.
module alu_pipe #(
  parameter int WIDTH = 8,
  parameter bit SAT   = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] C,
  output logic             carry,
  output logic             ovf,
  output logic             zero
);

  typedef enum logic [2:0] {
    OP_ADD     = 3'd0,
    OP_SUB     = 3'd1,
    OP_NOT_A   = 3'd2,
    OP_REDOR_B = 3'd3,
    OP_AND     = 3'd4,
    OP_XOR     = 3'd5,
    OP_ACC     = 3'd6,
    OP_ACC_CLR = 3'd7
  } op_e;

  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic             s1_valid;
  op_e              s1_op;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [WIDTH-1:0] acc;
  logic             adv2;

  logic [WIDTH:0]   sum_ext;
  logic [WIDTH-1:0] lhs;
  logic [WIDTH-1:0] rhs;
  logic [WIDTH-1:0] raw;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] acc_nxt;
  logic             c_nxt;
  logic             v_nxt;
  logic             arith;

  // Handshake: a beat moves on a rising edge when valid && ready on that side.
  // Stage 2 may advance when it is empty or its result is being taken; stage 1
  // may load when it is empty or stage 2 advances. Neither ready looks at valid.
  assign adv2     = !out_valid || out_ready;
  assign in_ready = !s1_valid || adv2;

  // ACC reuses the adder with the accumulator as the left operand.
  always_comb begin
    lhs     = (s1_op == OP_ACC) ? acc  : s1_a;
    rhs     = (s1_op == OP_ACC) ? s1_a : s1_b;
    sum_ext = (s1_op == OP_SUB) ? ({1'b0, lhs} - {1'b0, rhs})
                                : ({1'b0, lhs} + {1'b0, rhs});
    raw     = sum_ext[WIDTH-1:0];
    res     = raw;
    c_nxt   = 1'b0;
    v_nxt   = 1'b0;
    arith   = 1'b0;
    acc_nxt = acc;
    case (s1_op)
      OP_ADD, OP_ACC: begin
        arith = 1'b1;
        c_nxt = sum_ext[WIDTH];
        v_nxt = (lhs[WIDTH-1] == rhs[WIDTH-1]) && (raw[WIDTH-1] != lhs[WIDTH-1]);
      end
      OP_SUB: begin
        arith = 1'b1;
        c_nxt = sum_ext[WIDTH];
        v_nxt = (lhs[WIDTH-1] != rhs[WIDTH-1]) && (raw[WIDTH-1] != lhs[WIDTH-1]);
      end
      OP_NOT_A:   res = ~s1_a;
      OP_REDOR_B: res = {{(WIDTH-1){1'b0}}, |s1_b};
      OP_AND:     res = s1_a & s1_b;
      OP_XOR:     res = s1_a ^ s1_b;
      OP_ACC_CLR: begin
        res     = acc;
        acc_nxt = '0;
      end
      default: ;
    endcase
    // On overflow the true result has the sign of the left operand.
    if (SAT && arith && v_nxt) res = lhs[WIDTH-1] ? SMIN : SMAX;
    if (s1_op == OP_ACC) acc_nxt = res;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_op    <= OP_ADD;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_op <= op_e'(opcode);
        s1_a  <= A;
        s1_b  <= B;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      C         <= '0;
      carry     <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
      acc       <= '0;
    end else if (adv2) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        C     <= res;
        carry <= c_nxt;
        ovf   <= v_nxt;
        zero  <= (res == '0);
        acc   <= acc_nxt;
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: a wrapping and a saturating instance share one stimulus
// stream; results are scored against an integer-arithmetic reference model.
module tb_alu_pipe;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [2:0] opcode = 3'd0;
  logic [7:0] A = 8'd0;
  logic [7:0] B = 8'd0;

  logic       in_ready0, out_valid0, carry0, ovf0, zero0;
  logic       in_ready1, out_valid1, carry1, ovf1, zero1;
  logic [7:0] c0, c1;

  int errors = 0;
  int checks = 0;
  logic [10:0] exp_q0[$];
  logic [10:0] exp_q1[$];
  int acc_m0 = 0;
  int acc_m1 = 0;

  alu_pipe #(.WIDTH(8), .SAT(1'b0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
    .opcode(opcode), .A(A), .B(B), .out_valid(out_valid0), .out_ready(out_ready),
    .C(c0), .carry(carry0), .ovf(ovf0), .zero(zero0));

  alu_pipe #(.WIDTH(8), .SAT(1'b1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
    .opcode(opcode), .A(A), .B(B), .out_valid(out_valid1), .out_ready(out_ready),
    .C(c1), .carry(carry1), .ovf(ovf1), .zero(zero1));

  // clock
  always #5 clk = ~clk;

  // Reference model: signed/unsigned integer arithmetic; returns {C, carry, ovf, zero}.
  function automatic logic [10:0] ref_model(input logic [2:0] op, input logic [7:0] a,
                                            input logic [7:0] b, input bit sat,
                                            input int acc_in, output int acc_out);
    int ua, ub, sa, sb, sacc, t, wrap, c;
    bit cy, ov, ar;
    ua = a; ub = b;
    sa = (ua >= 128) ? ua - 256 : ua;
    sb = (ub >= 128) ? ub - 256 : ub;
    sacc = (acc_in >= 128) ? acc_in - 256 : acc_in;
    cy = 0; ov = 0; ar = 0; t = 0; wrap = 0; c = 0;
    acc_out = acc_in;
    case (op)
      3'd0: begin ar = 1; t = sa + sb; wrap = (ua + ub) % 256; cy = (ua + ub) > 255; end
      3'd1: begin ar = 1; t = sa - sb; wrap = (ua - ub + 256) % 256; cy = ua < ub; end
      3'd2: c = 255 - ua;
      3'd3: c = (ub != 0) ? 1 : 0;
      3'd4: c = int'(a & b);
      3'd5: c = int'(a ^ b);
      3'd6: begin ar = 1; t = sacc + sa; wrap = (acc_in + ua) % 256; cy = (acc_in + ua) > 255; end
      default: begin c = acc_in; acc_out = 0; end
    endcase
    if (ar) begin
      ov = (t > 127) || (t < -128);
      c  = (sat && ov) ? ((t > 127) ? 127 : 128) : wrap;
      if (op == 3'd6) acc_out = c;
    end
    return {8'(c), cy, ov, (c == 0)};
  endfunction

  task automatic push_expected(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int na;
    exp_q0.push_back(ref_model(op, a, b, 1'b0, acc_m0, na)); acc_m0 = na;
    exp_q1.push_back(ref_model(op, a, b, 1'b1, acc_m1, na)); acc_m1 = na;
  endtask

  // driver: present one op from just after a rising edge, hold until accepted
  task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int n;
    n = 0;
    in_valid = 1'b1; opcode = op; A = a; B = b;
    @(negedge clk);
    while (!in_ready0 && n < 50) begin
      @(posedge clk); #1;
      out_ready = 1'b1;
      n++;
      @(negedge clk);
    end
    checks++;
    assert (in_ready0 === 1'b1) else begin
      errors++; $error("FAIL accept_timeout got in_ready=%b exp 1", in_ready0);
    end
    if (in_ready0) push_expected(op, a, b);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int cycles);
    in_valid = 1'b0;
    repeat (cycles) begin @(posedge clk); #1; end
  endtask

  task automatic check_bit(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++; $error("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic check_byte(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++; $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // directed op with constant expectations for both instances
  task automatic run_one(input string tag, input logic [2:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] e0, input logic [7:0] e1,
                         input logic ecy, input logic eov, input logic ez);
    int n;
    send(op, a, b);
    in_valid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!out_valid0 && n < 10);
    checks++;
    assert ({out_valid0, c0, carry0, ovf0, zero0} === {1'b1, e0, ecy, eov, ez}) else begin
      errors++;
      $error("FAIL %s wrap got v=%b C=%0d cy=%b ov=%b z=%b exp v=1 C=%0d cy=%b ov=%b z=%b",
             tag, out_valid0, c0, carry0, ovf0, zero0, e0, ecy, eov, ez);
    end
    checks++;
    assert ({out_valid1, c1, carry1, ovf1, zero1} === {1'b1, e1, ecy, eov, e1 == 8'd0}) else begin
      errors++;
      $error("FAIL %s sat got v=%b C=%0d cy=%b ov=%b z=%b exp v=1 C=%0d cy=%b ov=%b z=%b",
             tag, out_valid1, c1, carry1, ovf1, zero1, e1, ecy, eov, e1 == 8'd0);
    end
    @(posedge clk); #1;
  endtask

  task automatic drain;
    int n;
    in_valid = 1'b0; out_ready = 1'b1; n = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && n < 200) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    assert (exp_q0.size() == 0 && exp_q1.size() == 0) else begin
      errors++; $error("FAIL drain got pending=%0d/%0d exp 0/0", exp_q0.size(), exp_q1.size());
    end
  endtask

  // scoreboard: every completed output transfer must match the queue head
  always @(negedge clk) begin
    if (!reset && out_ready && out_valid0) begin
      checks++;
      assert (exp_q0.size() != 0) else begin
        errors++; $error("FAIL sb_wrap_unexpected got C=%0d exp none", c0);
      end
      if (exp_q0.size() != 0) begin
        logic [10:0] e;
        e = exp_q0.pop_front();
        assert ({c0, carry0, ovf0, zero0} === e) else begin
          errors++; $error("FAIL sb_wrap got=%h exp=%h", {c0, carry0, ovf0, zero0}, e);
        end
      end
    end
    if (!reset && out_ready && out_valid1) begin
      checks++;
      assert (exp_q1.size() != 0) else begin
        errors++; $error("FAIL sb_sat_unexpected got C=%0d exp none", c1);
      end
      if (exp_q1.size() != 0) begin
        logic [10:0] e;
        e = exp_q1.pop_front();
        assert ({c1, carry1, ovf1, zero1} === e) else begin
          errors++; $error("FAIL sb_sat got=%h exp=%h", {c1, carry1, ovf1, zero1}, e);
        end
      end
    end
  end

  initial begin
    // reset state
    #12;
    check_byte("rst_c", c0, 8'd0);
    check_bit("rst_out_valid", out_valid0, 1'b0);
    check_bit("rst_flags", carry0 | ovf0 | zero0, 1'b0);
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    check_bit("rst_in_ready", in_ready0, 1'b1);
    @(posedge clk); #1;

    // reset with two ops in flight
    out_ready = 1'b0;
    send(3'd0, 8'd10, 8'd20);
    send(3'd0, 8'd30, 8'd40);
    in_valid = 1'b0;
    reset = 1'b1; #2;
    exp_q0.delete(); exp_q1.delete(); acc_m0 = 0; acc_m1 = 0;
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    check_bit("midrst_out_valid", out_valid0, 1'b0);
    check_byte("midrst_c", c0, 8'd0);
    check_bit("midrst_in_ready", in_ready0 & in_ready1, 1'b1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_bit("midrst_no_stale", out_valid0 | out_valid1, 1'b0);
    end
    @(posedge clk); #1;

    // directed arithmetic/logic cases
    run_one("add_carry", 3'd0, 8'd200, 8'd100, 8'd44, 8'd44, 1'b1, 1'b0, 1'b0);
    run_one("add_ovf", 3'd0, 8'd100, 8'd100, 8'd200, 8'd127, 1'b0, 1'b1, 1'b0);
    run_one("add_negovf", 3'd0, 8'h80, 8'hFF, 8'h7F, 8'h80, 1'b1, 1'b1, 1'b0);
    run_one("sub_borrow", 3'd1, 8'd5, 8'd7, 8'd254, 8'd254, 1'b1, 1'b0, 1'b0);
    run_one("redor_zero", 3'd3, 8'h55, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    run_one("not_a", 3'd2, 8'h0F, 8'h33, 8'hF0, 8'hF0, 1'b0, 1'b0, 1'b0);

    // back-to-back accumulator sequence: 0, 3, 7, 7, 1
    send(3'd7, 8'd0, 8'd0);
    send(3'd6, 8'd3, 8'd0);
    send(3'd6, 8'd4, 8'd0);
    send(3'd7, 8'd0, 8'd0);
    send(3'd6, 8'd1, 8'd0);
    drain();

    // backpressure: two ops buffer, the third waits for the release edge
    out_ready = 1'b0;
    send(3'd0, 8'd1, 8'd1);
    send(3'd0, 8'd2, 8'd2);
    in_valid = 1'b1; opcode = 3'd0; A = 8'd3; B = 8'd3;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_bit("bp_in_ready_low", in_ready0, 1'b0);
      check_byte("bp_c_held", c0, 8'd2);
      check_bit("bp_out_valid", out_valid0, 1'b1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    check_bit("bp_release_in_ready", in_ready0, 1'b1);
    if (in_ready0) push_expected(3'd0, 8'd3, 8'd3);
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();

    // randomized traffic with random backpressure
    for (int i = 0; i < 300; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 4) == 0) idle(1);
      send(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
    end
    drain();
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
